// File: rtl/sha256_host_master.sv
// Host-side sequencer for a register-mapped SHA-256 coprocessor.
// Accepts one padded 512-bit block, loads it, starts the core, polls STATUS
// until done (or a poll budget runs out), reads the digest, clears start and
// presents the result on a valid/ready response port.
module sha256_host_master #(
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [511:0]          req_block,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [255:0]          resp_hash,
  output logic                  resp_error,
  output logic                  wren,
  output logic                  rden,
  output logic [1:0]            address,
  output logic [31:0]           reg_data,
  output logic [15:0][31:0]     data_in,
  input  logic [31:0]           status_rdata,
  input  logic [7:0][31:0]      data_out
);

  localparam int unsigned CW = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_POLL, S_READ, S_CLEAR, S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [255:0]          hash_q, hash_d;
  logic [15:0][31:0]     blk_q, blk_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic [1:0]            address_q, address_d;
  logic [31:0]           reg_data_q, reg_data_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hash_d  = hash_q;
    blk_d   = blk_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Word 0 sits at the top of req_block but at index 0 of data_in:
          // reverse the 32-bit word order.
          blk_d   = {<<32{req_block}};
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        if (status_rdata == 32'd1) begin
          state_d = S_READ;
        end else begin
          if (cnt_q != CW'(POLL_TIMEOUT)) cnt_d = cnt_q + CW'(1);
          if (32'(cnt_q) + 32'd1 >= POLL_TIMEOUT) begin
            err_d   = 1'b1;
            hash_d  = '0;
            state_d = S_CLEAR;
          end
        end
      end
      S_READ: begin
        // data_out[0] must land in the most significant word.
        hash_d  = {<<32{data_out}};
        state_d = S_CLEAR;
      end
      S_CLEAR: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they are registered
    // yet aligned with the state they belong to.
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    wren_d       = (state_d == S_LOAD) || (state_d == S_START) || (state_d == S_CLEAR);
    rden_d       = (state_d == S_POLL) || (state_d == S_READ);
    reg_data_d   = (state_d == S_START) ? 32'd1 : 32'd0;
    unique case (state_d)
      S_LOAD:  address_d = 2'd2;
      S_POLL:  address_d = 2'd1;
      S_READ:  address_d = 2'd3;
      default: address_d = 2'd0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      hash_q       <= '0;
      blk_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      address_q    <= '0;
      reg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      hash_q       <= hash_d;
      blk_q        <= blk_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      wren_q       <= wren_d;
      rden_q       <= rden_d;
      address_q    <= address_d;
      reg_data_q   <= reg_data_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_hash  = hash_q;
  assign resp_error = err_q;
  assign wren       = wren_q;
  assign rden       = rden_q;
  assign address    = address_q;
  assign reg_data   = reg_data_q;
  assign data_in    = blk_q;

endmodule

// File: tb/tb_sha256_host_master.sv
// Directed bench for sha256_host_master with a small coprocessor model.
module tb_sha256_host_master;

  localparam logic [4:0] L_W2  = 5'b10100;
  localparam logic [4:0] L_W01 = 5'b10001;
  localparam logic [4:0] L_R1  = 5'b01010;
  localparam logic [4:0] L_R3  = 5'b01110;
  localparam logic [4:0] L_W00 = 5'b10000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic resp_ready = 1'b1;
  logic [511:0] req_block = '0;
  logic [7:0][31:0] dout = '0;

  logic req_ready, resp_valid, resp_error, wren, rden;
  logic [255:0] resp_hash;
  logic [1:0] address;
  logic [31:0] reg_data, st0;
  logic [15:0][31:0] data_in;

  logic t_req_ready, t_resp_valid, t_resp_error, t_wren, t_rden;
  logic [255:0] t_resp_hash;
  logic [1:0] t_address;
  logic [31:0] t_reg_data, st1;
  logic [15:0][31:0] t_data_in;

  int unsigned done_after = 0;
  logic st1_done = 1'b1;
  int unsigned polls0 = 0, polls1 = 0, viol = 0;
  logic [4:0] log0[$];
  logic [4:0] log1[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sha256_host_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_block(req_block), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hash(resp_hash), .resp_error(resp_error), .wren(wren), .rden(rden),
    .address(address), .reg_data(reg_data), .data_in(data_in),
    .status_rdata(st0), .data_out(dout)
  );

  sha256_host_master #(.POLL_TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(t_req_ready),
    .req_block(req_block), .resp_valid(t_resp_valid), .resp_ready(resp_ready),
    .resp_hash(t_resp_hash), .resp_error(t_resp_error), .wren(t_wren), .rden(t_rden),
    .address(t_address), .reg_data(t_reg_data), .data_in(t_data_in),
    .status_rdata(st1), .data_out(dout)
  );

  // Coprocessor model: STATUS reports done once done_after polls have completed.
  assign st0 = (polls0 >= done_after) ? 32'd1 : 32'hDEADBEEF;
  assign st1 = st1_done ? 32'd1 : 32'hDEADBEEF;

  // Bus monitor: count polls and log every strobe cycle.
  always @(posedge clk) begin
    if (reset) begin
      polls0 <= 0; polls1 <= 0;
      log0.delete(); log1.delete();
    end else begin
      if (rden && address == 2'd1) polls0 <= polls0 + 1;
      if (t_rden && t_address == 2'd1) polls1 <= polls1 + 1;
      if (wren || rden) log0.push_back({wren, rden, address, reg_data[0]});
      if (t_wren || t_rden) log1.push_back({t_wren, t_rden, t_address, t_reg_data[0]});
    end
    if ((wren && rden) || (t_wren && t_rden) || reg_data[31:1] != 0 || t_reg_data[31:1] != 0)
      viol <= viol + 1;
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [511:0]     blk;
    logic [7:0][31:0] dout;
    int unsigned      done_after;
    int unsigned      exp_lat;
    int unsigned      exp_polls;
    logic [255:0]     exp_hash;
    logic [31:0]      exp_w0;
    logic [31:0]      exp_w15;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int lat;
    int unsigned pb;
    logic [255:0] h;
    int r1, r2;
    logic [255:0] hr1, hr2;

    vecs[0] = '{blk: {32'h61626380, 448'd0, 32'h00000018},
                dout: {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                       32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf},
                done_after: 0, exp_lat: 6, exp_polls: 1,
                exp_hash: 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad,
                exp_w0: 32'h61626380, exp_w15: 32'h00000018};
    vecs[1] = '{blk: {32'hcafef00d, 448'd0, 32'h12345678},
                dout: {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                       32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                done_after: 7, exp_lat: 13, exp_polls: 8,
                exp_hash: 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
                exp_w0: 32'hcafef00d, exp_w15: 32'h12345678};
    vecs[2] = '{blk: {32'h80000001, 448'h5, 32'h0},
                dout: {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'hffffffff},
                done_after: 2, exp_lat: 8, exp_polls: 3,
                exp_hash: 256'hffffffff_00000001_00000002_00000003_00000004_00000005_00000006_00000007,
                exp_w0: 32'h80000001, exp_w15: 32'h0};

    // Reset state.
    do_reset();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_hash", resp_hash, 0);
    chk("rst_error", resp_error, 0);
    chk("rst_strobes", {wren, rden, address}, 0);
    chk("rst_reg_data", reg_data, 0);
    chk("rst_data_in", data_in, 0);

    // Table-driven jobs.
    foreach (vecs[v]) begin
      do_reset();
      done_after = vecs[v].done_after;
      dout = vecs[v].dout;
      req_block = vecs[v].blk;
      resp_ready = 1'b1;
      req_valid = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (k == 1) begin
          req_valid = 1'b0;
          chk("load_strobe", {wren, rden, address}, {1'b1, 1'b0, 2'd2});
          chk("load_w0", data_in[0], vecs[v].exp_w0);
          chk("load_w15", data_in[15], vecs[v].exp_w15);
        end
        if (resp_valid) begin
          lat = k;
          break;
        end
      end
      chk("latency", lat, vecs[v].exp_lat);
      chk("hash", resp_hash, vecs[v].exp_hash);
      chk("error", resp_error, 0);
      chk("polls", polls0, vecs[v].exp_polls);
      chk("log_size", log0.size(), 4 + vecs[v].exp_polls);
      if (log0.size() >= 5) begin
        chk("log_first", log0[0], L_W2);
        chk("log_start", log0[1], L_W01);
        chk("log_poll", log0[2], L_R1);
        chk("log_read", log0[log0.size() - 2], L_R3);
        chk("log_clear", log0[log0.size() - 1], L_W00);
      end
      @(negedge clk);
      chk("resp_one_cycle", {resp_valid, req_ready}, 2'b01);
    end

    // Timeout on the POLL_TIMEOUT=4 instance, after a successful job.
    do_reset();
    done_after = 0; st1_done = 1'b1;
    dout = vecs[0].dout; req_block = vecs[0].blk;
    req_valid = 1'b1; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (t_resp_valid) begin lat = k; break; end
    end
    chk("t_ok_latency", lat, 6);
    chk("t_ok_hash", t_resp_hash, vecs[0].exp_hash);
    @(negedge clk);
    st1_done = 1'b0; pb = polls1;
    req_valid = 1'b1; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (t_resp_valid) begin lat = k; break; end
    end
    chk("t_to_latency", lat, 8);
    chk("t_to_polls", polls1 - pb, 4);
    chk("t_to_error", t_resp_error, 1);
    chk("t_to_hash", t_resp_hash, 0);
    chk("t_to_log_size", log1.size(), 12);
    if (log1.size() >= 2) begin
      chk("t_to_last", log1[log1.size() - 1], L_W00);
      chk("t_to_no_read", log1[log1.size() - 2], L_R1);
    end
    st1_done = 1'b1;

    // Backpressure with stray req_valid pulses during the job and in RESP.
    do_reset();
    done_after = 0; dout = vecs[0].dout; req_block = vecs[0].blk;
    resp_ready = 1'b0; req_valid = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      req_valid = (k == 2 || k == 8);
      if (k <= 11) chk("bp_req_ready", req_ready, 0);
      if (k == 6) h = resp_hash;
      if (k >= 6 && k <= 11) begin
        chk("bp_valid", resp_valid, 1);
        chk("bp_hash", resp_hash, vecs[0].exp_hash);
      end
      if (k == 11) resp_ready = 1'b1;
      if (k == 12) chk("bp_release", {resp_valid, req_ready}, 2'b01);
      if (k == 13) chk("bp_no_new_job", {wren, req_ready}, 2'b01);
    end
    chk("bp_hash_stable", resp_hash, h);
    chk("bp_polls", polls0, 1);
    chk("bp_log_size", log0.size(), 5);

    // Reset while polling: no CLEAR write, no response.
    do_reset();
    done_after = 100; req_block = vecs[1].blk; req_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("rp_in_poll", {rden, address}, {1'b1, 2'd1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rp_idle", {req_ready, resp_valid, resp_error, wren, rden, address}, 7'b1000000);
    chk("rp_reg_data", reg_data, 0);
    chk("rp_data_in", data_in, 0);
    chk("rp_hash", resp_hash, 0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("rp_no_access", log0.size(), 0);
    chk("rp_no_resp", resp_valid, 0);

    // Back-to-back jobs with req_valid held until the second acceptance.
    do_reset();
    done_after = 0; dout = vecs[0].dout; req_block = vecs[0].blk;
    resp_ready = 1'b1; req_valid = 1'b1;
    r1 = 0; r2 = 0; hr1 = '0; hr2 = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 5) begin dout = vecs[1].dout; req_block = vecs[1].blk; end
      if (k == 8) begin
        req_valid = 1'b0;
        chk("b2b_second_load", {wren, address}, {1'b1, 2'd2});
        chk("b2b_second_w0", data_in[0], vecs[1].exp_w0);
      end
      if (resp_valid && r1 == 0) begin r1 = k; hr1 = resp_hash; end
      else if (resp_valid && r2 == 0) begin r2 = k; hr2 = resp_hash; end
    end
    chk("b2b_first_cycle", r1, 6);
    chk("b2b_first_hash", hr1, vecs[0].exp_hash);
    chk("b2b_second_cycle", r2, 13);
    chk("b2b_second_hash", hr2, vecs[1].exp_hash);

    chk("strobe_exclusive", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
